// File: rtl/alu_result_writeback.sv
// alu_result_writeback
//   In-order writeback buffer between the ALU output register and the
//   register-file write arbiter. It holds up to DEPTH pending results and
//   drains them oldest-first through a request/grant write port. A
//   combinational forwarding lookup returns the youngest pending value for a
//   queried register.
//
// Ports
//   clk, reset             clock; asynchronous active-high reset
//   in_valid/in_ready      ALU-side handshake; in_data, in_rd carry the result
//   rf_req/rf_grant        write-port request and arbiter grant
//   rf_waddr, rf_wdata     head entry presented to the register file
//   flush                  synchronous discard of every pending entry
//   fwd_rs                 register queried by hazard logic
//   fwd_hit, fwd_data      forwarding result (youngest matching entry)
//   count                  number of valid entries
module alu_result_writeback #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int DEPTH      = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DATA_WIDTH-1:0]      in_data,
    input  logic [ADDR_WIDTH-1:0]      in_rd,
    output logic                       rf_req,
    input  logic                       rf_grant,
    output logic [ADDR_WIDTH-1:0]      rf_waddr,
    output logic [DATA_WIDTH-1:0]      rf_wdata,
    input  logic                       flush,
    input  logic [ADDR_WIDTH-1:0]      fwd_rs,
    output logic                       fwd_hit,
    output logic [DATA_WIDTH-1:0]      fwd_data,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] rd;
        logic [DATA_WIDTH-1:0] data;
    } entry_t;

    entry_t        mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count_q;

    logic full;
    logic push;
    logic pop;

    assign full     = (count_q == CW'(DEPTH));
    // Held low during reset so the ALU side never hands over a result that
    // the asynchronous clear would silently drop.
    assign in_ready = !reset && !full;
    assign rf_req   = (count_q != '0);
    assign rf_waddr = mem[rd_ptr].rd;
    assign rf_wdata = mem[rd_ptr].data;
    assign count    = count_q;

    // A handshake aimed at r0 completes but stores nothing.
    assign push = in_valid && in_ready && !flush && (in_rd != '0);
    assign pop  = rf_req && rf_grant && !flush;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= '{rd: in_rd, data: in_data};
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Forwarding: walk oldest to youngest so the last match is the youngest.
    logic [PW-1:0] idx;
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        idx      = rd_ptr;
        for (int k = 0; k < DEPTH; k++) begin
            idx = rd_ptr + PW'(k);
            if ((CW'(k) < count_q) && (fwd_rs != '0) && (mem[idx].rd == fwd_rs)) begin
                fwd_hit  = 1'b1;
                fwd_data = mem[idx].data;
            end
        end
    end

endmodule

// File: doc/alu_result_writeback.md
# alu_result_writeback

Writeback stage that drains registered ALU results into the register-file write port. It sits between the ALU output register and the register-file write arbiter, which it shares with the load path. It buffers up to DEPTH pending results in order, so the ALU side can keep issuing while the write port is busy. It also exposes a forwarding lookup so hazard logic can read pending values that have not yet reached the register file.

## Interface
- DATA_WIDTH, 32, result/data width
- ADDR_WIDTH, 5, register index width
- DEPTH, 2, buffer entries; power of two, ≥2
- clk  input  1  clock, all state updates on rising edge
- reset  input  1  asynchronous, active-high reset
- in_valid  input  1  ALU side offers a result this cycle
- in_ready  output  1  buffer can accept; equals !full, forced 0 while reset asserted
- in_data  input  DATA_WIDTH  result value
- in_rd  input  ADDR_WIDTH  destination register
- rf_req  output  1  head entry requests the write port
- rf_grant  input  1  arbiter grants the port this cycle
- rf_waddr  output  ADDR_WIDTH  head destination register
- rf_wdata  output  DATA_WIDTH  head value
- flush  input  1  discard all pending entries
- fwd_rs  input  ADDR_WIDTH  register queried by hazard logic
- fwd_hit  output  1  a pending entry targets fwd_rs
- fwd_data  output  DATA_WIDTH  value from the youngest matching entry
- count  output  $clog2(DEPTH)+1  number of valid entries

## Operation
- Circular FIFO: write pointer, read pointer, and count register. Both pointers wrap modulo DEPTH.
- Push condition: in_valid && in_ready && !flush && in_rd != 0.
  - A handshake with in_rd == 0 is accepted (in_ready is honoured) but no entry is stored. Register 0 is never written.
- Pop condition: rf_req && rf_grant && !flush.
- Push and pop in the same cycle: both take effect and count is unchanged. This can only occur when 0 < count < DEPTH.
- Full (count == DEPTH):
  - in_ready = 0, even if a pop occurs that cycle.
  - There is no same-cycle pass-through.
- Empty (count == 0):
  - rf_req = 0.
  - rf_waddr and rf_wdata show the stale slot at the read pointer; these values are don't-care.
- While rf_req = 1 and rf_grant = 0:
  - rf_req stays asserted.
  - rf_waddr and rf_wdata stay stable until the grant arrives.
- Entries drain in strict arrival order.
- Flush:
  - Synchronous.
  - At the next edge, count, write pointer and read pointer all become 0.
  - Flush overrides any push or pop in the same cycle. A result offered alongside flush is lost, and a granted write in that cycle does not pop. The arbiter must not commit a write when flush is high.
- Forwarding (combinational):
  - fwd_hit = 1 iff fwd_rs != 0 and at least one valid entry has rd == fwd_rs.
  - fwd_data is taken from the most recently pushed matching entry. It is 0 when there is no hit.
  - The current-cycle input is not included in the lookup.
- Outputs are driven directly from storage. rf_* and fwd_* contain no path from in_*.

## Timing
- Reset (asynchronous assert): count = 0, pointers = 0, all entries cleared to 0. Consequently rf_req = 0, rf_waddr = 0, rf_wdata = 0, fwd_hit = 0, fwd_data = 0, in_ready = 0.
- First cycle after reset deasserts: in_ready = 1.
- Latency:
  - A result pushed at edge N is presented with rf_req = 1 in cycle N+1 if the buffer was empty.
  - If rf_grant = 1 in that cycle, the entry pops at edge N+1.
  - Minimum input-to-write latency is one cycle.
- Sustained throughput is one result per cycle when rf_grant is held high.
- Reset asserted mid-operation: all pending entries are lost immediately, with no partial write. rf_req drops in the same cycle reset asserts.
- Forwarding reflects the state after the last edge, so it is valid in the same cycle fwd_rs is presented.

## Test plan
- Reset and idle: assert reset mid-cycle with 2 entries held -> rf_req, count, fwd_hit read 0 immediately, before any edge; in_ready = 1 one cycle after release.
- Single write: push rd=3, data=0x0000_00AA with rf_grant=1 -> next cycle rf_req=1, rf_waddr=3, rf_wdata=0xAA; count returns to 0 after that edge.
- Back-pressure to full: with rf_grant=0, push rd=1/0x11 and rd=2/0x22 -> count=2, in_ready=0, rf_waddr=1 held; raise grant -> writes 1 then 2 in consecutive cycles.
- Forwarding priority: push rd=5/0x10 then rd=5/0x20 with grant=0; query fwd_rs=5 -> fwd_hit=1, fwd_data=0x20. Query fwd_rs=0 -> fwd_hit=0.
- R0 discard: push rd=0/0xDEAD -> in_ready=1 in that cycle, count stays 0, rf_req never asserts.
- Flush collision: count=1, assert flush together with in_valid (rd=7) and rf_grant=1 -> after the edge count=0 and rf_req=0; rd=7 never appears on rf_waddr.
